// File: rtl/sseg_pkg.sv
// Shared constants for the front-panel seven-segment scanner: active-low
// gfedcba glyphs, digit-slot state encoding and the default refresh divider.
package sseg_pkg;
    localparam int SCAN_DIV_DEF = 50000;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {D0, D1, D2, D3} digit_e;
endpackage

// File: rtl/bcd_sseg_scanner_if.sv
// Panel bus: BCD value/strobe/enable in, active-low anode/cathode/dp out.
interface bcd_sseg_scanner_if;
    logic [11:0] bcd_in;
    logic        load;
    logic        enable;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (output bcd_in, load, enable, input an, seg, dp);
    modport slave  (input bcd_in, load, enable, output an, seg, dp);
endinterface

// File: rtl/bcd_to_sseg.sv
// Nibble to active-low gfedcba glyph; non-decimal codes render as a dash.
module bcd_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);
    always_comb begin
        glyph = GLYPH_DASH;
        case (nib)
            4'd0: glyph = GLYPH_0;
            4'd1: glyph = GLYPH_1;
            4'd2: glyph = GLYPH_2;
            4'd3: glyph = GLYPH_3;
            4'd4: glyph = GLYPH_4;
            4'd5: glyph = GLYPH_5;
            4'd6: glyph = GLYPH_6;
            4'd7: glyph = GLYPH_7;
            4'd8: glyph = GLYPH_8;
            4'd9: glyph = GLYPH_9;
            default: glyph = GLYPH_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_sseg_scanner.sv
// Four-slot common-anode scanner for a latched 3-digit BCD value with
// leading-zero blanking; all panel outputs are registered.
module bcd_sseg_scanner
    import sseg_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_sseg_scanner_if.slave  bus
);
    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          tick;
    digit_e        state_q, state_d;
    logic [11:0]   bcd_q;
    logic [3:0]    nib, an_sel, an_q;
    logic [6:0]    glyph, seg_q;
    logic          blank;

    assign tick = (div_cnt == DIV_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            state_q <= D0;
            bcd_q   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            state_q <= state_d;
            if (bus.load) bcd_q <= bus.bcd_in;
        end
    end

    // Slot select and blanking; invalid nibbles are nonzero so they never blank.
    always_comb begin
        state_d = state_q;
        nib     = bcd_q[3:0];
        an_sel  = 4'b1110;
        blank   = 1'b0;
        case (state_q)
            D0: begin
                nib    = bcd_q[3:0];
                an_sel = 4'b1110;
                if (tick) state_d = D1;
            end
            D1: begin
                nib    = bcd_q[7:4];
                an_sel = 4'b1101;
                blank  = BLANK_LZ && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
                if (tick) state_d = D2;
            end
            D2: begin
                nib    = bcd_q[11:8];
                an_sel = 4'b1011;
                blank  = BLANK_LZ && (bcd_q[11:8] == 4'd0);
                if (tick) state_d = D3;
            end
            default: begin
                nib    = 4'd0;
                an_sel = 4'b0111;
                blank  = 1'b1;
                if (tick) state_d = D0;
            end
        endcase
    end

    bcd_to_sseg u_dec (.nib(nib), .glyph(glyph));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= AN_OFF;
            seg_q <= GLYPH_BLANK;
        end else if (!bus.enable || blank) begin
            an_q  <= AN_OFF;
            seg_q <= GLYPH_BLANK;
        end else begin
            an_q  <= an_sel;
            seg_q <= glyph;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = 1'b1;
endmodule

// File: tb/tb_bcd_sseg_scanner.sv
// Scoreboarded bench: two scanners (blanking on/off) share stimulus; expected
// {an,seg} comes from a slot-timing model and is queued per driven cycle.
module tb_bcd_sseg_scanner;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   k = 1;
    logic [11:0] m_bcd = '0;
    logic [10:0] q_a[$];
    logic [10:0] q_b[$];

    bcd_sseg_scanner_if ifa ();
    bcd_sseg_scanner_if ifb ();

    bcd_sseg_scanner #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    bcd_sseg_scanner #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Expected {an,seg} for a slot index, held value, enable and blanking mode.
    function automatic logic [10:0] model(input int slot, input logic [11:0] b,
                                          input logic en, input bit blz);
        logic [3:0] h, t, o;
        h = b[11:8];
        t = b[7:4];
        o = b[3:0];
        if (!en) return {4'b1111, 7'b1111111};
        case (slot)
            0: return {4'b1110, glyph(o)};
            1: return (blz && h == 4'd0 && t == 4'd0) ? {4'b1111, 7'b1111111} : {4'b1101, glyph(t)};
            2: return (blz && h == 4'd0) ? {4'b1111, 7'b1111111} : {4'b1011, glyph(h)};
            default: return {4'b1111, 7'b1111111};
        endcase
    endfunction

    task automatic drive(input logic ld, input logic [11:0] b, input logic en);
        ifa.load = ld; ifa.bcd_in = b; ifa.enable = en;
        ifb.load = ld; ifb.bcd_in = b; ifb.enable = en;
    endtask

    task automatic step(input logic ld, input logic [11:0] b, input logic en);
        int slot;
        logic [10:0] ea, eb;
        drive(ld, b, en);
        slot = ((k - 1) / SD) % 4;
        q_a.push_back(model(slot, m_bcd, en, 1'b1));
        q_b.push_back(model(slot, m_bcd, en, 1'b0));
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        chk("out_lz1", {21'd0, ifa.an, ifa.seg}, {21'd0, ea});
        chk("out_lz0", {21'd0, ifb.an, ifb.seg}, {21'd0, eb});
        chk("dp", {31'd0, ifa.dp & ifb.dp}, 32'd1);
        chk("an_onehot", {31'd0, ($countones(~ifa.an) <= 1) && ($countones(~ifb.an) <= 1)}, 32'd1);
        if (ld) m_bcd = b;
        k++;
    endtask

    task automatic run(input int n, input logic en);
        for (int i = 0; i < n; i++) step(1'b0, 12'h000, en);
    endtask

    initial begin
        int guard;
        drive(1'b0, 12'h000, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", {28'd0, ifa.an}, 32'hf);
        chk("rst_seg", {25'd0, ifa.seg}, 32'h7f);
        chk("rst_dp", {31'd0, ifa.dp}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        k = 1;
        m_bcd = '0;
        // first edge must light the ones digit with "0"
        step(1'b0, 12'h000, 1'b1);
        chk("first_an", {28'd0, ifa.an}, 32'he);
        chk("first_seg", {25'd0, ifa.seg}, 32'h40);
        run(15, 1'b1);

        step(1'b1, 12'h255, 1'b1);
        run(18, 1'b1);

        step(1'b1, 12'h007, 1'b1);
        run(18, 1'b1);

        step(1'b1, 12'h0A3, 1'b1);
        run(18, 1'b1);

        step(1'b1, 12'h255, 1'b1);
        run(5, 1'b1);
        run(5, 1'b0);
        run(10, 1'b1);

        step(1'b1, 12'h111, 1'b1);
        step(1'b1, 12'h908, 1'b1);
        run(18, 1'b1);

        // Walk into the hundreds slot, then pull reset between edges.
        step(1'b1, 12'h255, 1'b1);
        guard = 0;
        while ((((k - 2) / SD) % 4) != 2 && guard < 20) begin
            step(1'b0, 12'h000, 1'b1);
            guard++;
        end
        chk("reach_d2", {28'd0, ifa.an}, 32'hb);
        rst_n = 1'b0;
        #1;
        chk("async_an", {28'd0, ifa.an}, 32'hf);
        chk("async_seg", {25'd0, ifa.seg}, 32'h7f);
        chk("async_an_b", {28'd0, ifb.an}, 32'hf);
        @(negedge clk);
        rst_n = 1'b1;
        k = 1;
        m_bcd = '0;
        step(1'b0, 12'h000, 1'b1);
        chk("restart_an", {28'd0, ifb.an}, 32'he);
        run(9, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
